// File: rtl/sum_result_fifo_if.sv
// sum_result_fifo_if -- handshake bundle for the summing result FIFO.
//
// Signals:
//   in_valid   one-cycle result strobe from the upstream adder
//   in_data    upstream adder result, W bits
//   out_valid  head entry available
//   out_ready  consumer accepts the head entry
//   out_data   head entry, first-word-fall-through
//
// Modports:
//   master  environment side: drives the upstream strobe/data and the consumer ready
//   slave   FIFO side
interface sum_result_fifo_if #(
    parameter int W = 12
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sum_result_fifo.sv
// sum_result_fifo -- small FWFT FIFO buffering results of an upstream adder,
// with sticky overflow flag and optional running sum of consumed entries.
//
// Parameters:
//   W      data width (matches the upstream adder result width)
//   DEPTH  number of entries, power of two, >= 2
//
// Ports:
//   clk       single clock, all state updates on posedge
//   rst_n     asynchronous active-low reset
//   bus       sum_result_fifo_if.slave: in_valid/in_data (push side, no
//             backpressure), out_valid/out_ready/out_data (pop side)
//   count     current occupancy, 0..DEPTH
//   overflow  sticky: a result was dropped because the FIFO was full
//   acc       running sum of popped entries modulo 2^(W+4)
//
// Build option:
//   SUM_ACC_EN  when defined, acc accumulates every popped entry; otherwise
//               acc is tied to zero and no accumulator register exists.
module sum_result_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sum_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [W+3:0]             acc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    always_comb begin
        full = (count == CW'(DEPTH));
        pop  = bus.out_valid && bus.out_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push = bus.in_valid && (!full || pop);
        drop = bus.in_valid && full && !pop;
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SUM_ACC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (pop) begin
            acc <= acc + {4'b0000, bus.out_data};
        end
    end
`else
    assign acc = '0;
`endif

endmodule

// File: tb/tb_sum_result_fifo.sv
// tb_sum_result_fifo -- directed self-checking bench for sum_result_fifo
// (W=12, DEPTH=4). Inputs change 1 time unit after each posedge; outputs are
// checked in the same window, well away from the next active edge.
// Expected acc values follow SUM_ACC_EN: the running sum when defined, 0 otherwise.
module tb_sum_result_fifo;
    localparam int W     = 12;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic [2:0]    count;
    logic          overflow;
    logic [W+3:0]  acc;

    int unsigned   total;
    int unsigned   bad;
    logic [15:0]   sum_model;
    logic [W-1:0]  vals [10];

    sum_result_fifo_if #(.W(W)) bus ();

    sum_result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .count    (count),
        .overflow (overflow),
        .acc      (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_acc(input logic [15:0] m);
`ifdef SUM_ACC_EN
        return m;
`else
        return 16'h0000 & m;
`endif
    endfunction

    initial begin
        total         = 0;
        bad           = 0;
        sum_model     = '0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 12'h055;
        bus.out_ready = 1'b0;

        // Reset held 3 cycles with a live strobe
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            chk("rst_acc", 32'(acc), 32'd0);
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Single pass-through; out_ready=1 while empty is ignored
        bus.in_valid  = 1'b1;
        bus.in_data   = 12'h123;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("pt_count1", 32'(count), 32'd1);
        chk("pt_valid", 32'(bus.out_valid), 32'd1);
        chk("pt_data", 32'(bus.out_data), 32'h123);
        step();
        sum_model = sum_model + 16'h123;
        chk("pt_count0", 32'(count), 32'd0);
        chk("pt_valid0", 32'(bus.out_valid), 32'd0);
        chk("pt_acc", 32'(acc), 32'(exp_acc(sum_model)));

        // Fill to full then overflow with the fifth push
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(i);
            step();
            if (i == 4) begin
                chk("fill_count4", 32'(count), 32'd4);
                chk("fill_ovf_pre", 32'(overflow), 32'd0);
            end
        end
        bus.in_valid = 1'b0;
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_data", 32'(bus.out_data), 32'(k));
            step();
            sum_model = sum_model + 16'(k);
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("drain_acc", 32'(acc), 32'(exp_acc(sum_model)));

        // Pulse reset between edges to clear the sticky flag
        rst_n = 1'b0;
        #2;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_acc", 32'(acc), 32'd0);
        rst_n     = 1'b1;
        sum_model = '0;

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(i);
            step();
        end
        chk("fp_count_full", 32'(count), 32'd4);
        bus.in_data   = 12'h009;
        bus.out_ready = 1'b1;
        chk("fp_head", 32'(bus.out_data), 32'd1);
        step();
        sum_model     = sum_model + 16'd1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("fp_count", 32'(count), 32'd4);
        chk("fp_ovf", 32'(overflow), 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] e;
            e = (k == 3) ? 12'h009 : 12'(k + 2);
            chk("fp_valid", 32'(bus.out_valid), 32'd1);
            chk("fp_data", 32'(bus.out_data), 32'(e));
            step();
            sum_model = sum_model + 16'(e);
        end
        bus.out_ready = 1'b0;
        chk("fp_empty", 32'(bus.out_valid), 32'd0);
        chk("fp_acc", 32'(acc), 32'(exp_acc(sum_model)));

        // Wrap-around: one strobe every 4 cycles, popped the cycle after
        for (int r = 0; r < 10; r++) begin
            vals[r]      = 12'($urandom_range(0, 1023));
            bus.in_valid = 1'b1;
            bus.in_data  = vals[r];
            step();
            bus.in_valid = 1'b0;
            chk("wr_valid", 32'(bus.out_valid), 32'd1);
            chk("wr_data", 32'(bus.out_data), 32'(vals[r]));
            bus.out_ready = 1'b1;
            step();
            sum_model     = sum_model + 16'(vals[r]);
            bus.out_ready = 1'b0;
            chk("wr_count", 32'(count), 32'd0);
            step();
            step();
        end
        chk("wr_acc", 32'(acc), 32'(exp_acc(sum_model)));
        chk("wr_ovf", 32'(overflow), 32'd0);

        // Mid-operation reset discards stored entries
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(12'h0A0 + i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("mr_count3", 32'(count), 32'd3);
        rst_n = 1'b0;
        #2;
        chk("mr_count0", 32'(count), 32'd0);
        chk("mr_valid0", 32'(bus.out_valid), 32'd0);
        rst_n     = 1'b1;
        sum_model = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h7FF;
        step();
        bus.in_valid = 1'b0;
        chk("mr_count1", 32'(count), 32'd1);
        chk("mr_data", 32'(bus.out_data), 32'h7FF);
        bus.out_ready = 1'b1;
        step();
        sum_model = sum_model + 16'h7FF;
        for (int i = 0; i < 3; i++) begin
            chk("mr_after_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        bus.out_ready = 1'b0;
        chk("mr_after_count", 32'(count), 32'd0);
        chk("mr_acc", 32'(acc), 32'(exp_acc(sum_model)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
